// File: rtl/line_buffer_taps.sv
// Purpose : single-line pixel buffer presenting a TAPS-wide horizontal window.
// Latency : o_data is combinational from memory/rd_ptr (zero cycles); o_line_done one cycle after the last read.
// Backpressure: writes are refused while o_wr_ready=0 (full); reads are ignored while o_data_valid=0.
//
// Ports:
//   i_clk, i_rst        - clock, asynchronous active-high reset
//   i_data/i_data_valid - write pixel / write request; o_wr_ready = room for a write
//   i_rd_data           - advance the window by one pixel
//   o_data              - window, tap k (address rd_ptr+k) at [k*DATA_W +: DATA_W]
//   o_data_valid        - window holds TAPS written pixels
//   o_line_done         - one-cycle pulse after the last window of a line is read
//   o_count             - occupancy; o_err - {underflow, overflow} sticky flags
// Build option: define LB_ERR_FLAG_EN to enable the sticky o_err flags
// (otherwise o_err is tied to 2'b00).
module line_buffer_taps #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 512,
  parameter int TAPS   = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DATA_W-1:0]           i_data,
  input  logic                        i_data_valid,
  output logic                        o_wr_ready,
  input  logic                        i_rd_data,
  output logic [TAPS*DATA_W-1:0]      o_data,
  output logic                        o_data_valid,
  output logic                        o_line_done,
  output logic [$clog2(LINE_W+1)-1:0] o_count,
  output logic [1:0]                  o_err
);

  localparam int CNT_W = $clog2(LINE_W + 1);
  localparam int PTR_W = $clog2(LINE_W);

  localparam logic [PTR_W-1:0] LAST_WR = PTR_W'(LINE_W - 1);
  localparam logic [PTR_W-1:0] LAST_RD = PTR_W'(LINE_W - TAPS);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(LINE_W);
  localparam logic [CNT_W-1:0] TAPS_C  = CNT_W'(TAPS);

  logic [DATA_W-1:0] mem [LINE_W];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              wr_acc;
  logic              rd_acc;
  logic              rd_last;
  logic [CNT_W-1:0]  release_n;
  logic [CNT_W-1:0]  count_nxt;

  // Handshakes are judged on the pre-edge occupancy, so a full buffer that is
  // read and written in the same cycle still refuses the write.
  assign o_wr_ready   = (count < FULL_C);
  assign o_data_valid = (count >= TAPS_C);
  assign o_count      = count;

  assign wr_acc  = i_data_valid & o_wr_ready;
  assign rd_acc  = i_rd_data & o_data_valid;
  assign rd_last = (rd_ptr == LAST_RD);

  // A mid-line advance frees only the oldest pixel; the last window of a line
  // frees all TAPS pixels it covers, since the next line starts at address 0.
  always_comb begin
    release_n = '0;
    if (rd_acc) begin
      release_n = rd_last ? TAPS_C : CNT_W'(1);
    end
  end

  // release_n never exceeds count, and a write only lands when count < LINE_W,
  // so this stays within 0..LINE_W.
  assign count_nxt = count + CNT_W'(wr_acc) - release_n;

  // The window never straddles the end of the line: rd_ptr <= LINE_W-TAPS.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign o_data[k*DATA_W +: DATA_W] = mem[rd_ptr + PTR_W'(k)];
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_line_done <= 1'b0;
    end else begin
      count       <= count_nxt;
      o_line_done <= rd_acc & rd_last;
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_WR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_last ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

`ifdef LB_ERR_FLAG_EN
  logic [1:0] err_q;

  // Sticky until reset: bit0 a refused write, bit1 a refused read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 2'b00;
    end else begin
      if (i_data_valid && !o_wr_ready) err_q[0] <= 1'b1;
      if (i_rd_data && !o_data_valid) err_q[1] <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_line_buffer_taps.sv
module tb_line_buffer_taps;

  localparam int DATA_W = 8;
  localparam int LINE_W = 8;
  localparam int TAPS   = 3;

  logic                 clk;
  logic                 rst;
  logic [DATA_W-1:0]    data;
  logic                 data_valid;
  logic                 wr_ready;
  logic                 rd_data;
  logic [TAPS*DATA_W-1:0] win;
  logic                 win_valid;
  logic                 line_done;
  logic [3:0]           count;
  logic [1:0]           err;

  line_buffer_taps #(.DATA_W(DATA_W), .LINE_W(LINE_W), .TAPS(TAPS)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(data_valid),
    .o_wr_ready(wr_ready), .i_rd_data(rd_data), .o_data(win),
    .o_data_valid(win_valid), .o_line_done(line_done), .o_count(count),
    .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the unreleased pixels in write order, and how many
  // windows of the current line have been read.
  logic [DATA_W-1:0] q[$];
  int                pos;
  logic              m_done;
  logic [1:0]        m_err;
  logic              last_ra;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pos    = 0;
    m_done = 1'b0;
    m_err  = 2'b00;
  endtask

  task automatic model_check();
    chk("count", 32'(count), 32'(q.size()));
    chk("wr_ready", 32'(wr_ready), 32'(q.size() < LINE_W));
    chk("data_valid", 32'(win_valid), 32'(q.size() >= TAPS));
    chk("line_done", 32'(line_done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    if (q.size() >= TAPS) chk("window", 32'(win), {8'h00, q[2], q[1], q[0]});
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle by #1.
  task automatic apply(input logic dv, input logic [DATA_W-1:0] d, input logic rd);
    @(negedge clk);
    data_valid = dv;
    data       = d;
    rd_data    = rd;
    #1;
  endtask

  // Compare against the model, then let the rising edge commit the cycle.
  task automatic commit();
    logic wa, ra;
    model_check();
    wa = data_valid && (q.size() < LINE_W);
    ra = rd_data && (q.size() >= TAPS);
`ifdef LB_ERR_FLAG_EN
    if (data_valid && !wa) m_err[0] = 1'b1;
    if (rd_data && !ra)    m_err[1] = 1'b1;
`endif
    @(posedge clk);
    last_ra = ra;
    m_done  = ra && (pos == LINE_W - TAPS);
    if (ra) begin
      if (pos == LINE_W - TAPS) begin
        for (int i = 0; i < TAPS; i++) void'(q.pop_front());
        pos = 0;
      end else begin
        void'(q.pop_front());
        pos++;
      end
    end
    if (wa) q.push_back(data);
  endtask

  task automatic cyc(input logic dv, input logic [DATA_W-1:0] d, input logic rd);
    apply(dv, d, rd);
    commit();
  endtask

  // Asynchronous reset applied between clock edges and checked at once.
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    data_valid = 1'b0;
    rd_data    = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(win_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_done", 32'(line_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic              dv;
    logic [DATA_W-1:0] d;
    logic              rd;
    int                cnt;
    logic              vld;
    logic [23:0]       dat;
    logic              done;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic dv, input logic [7:0] d, input logic rd,
                              input int cnt, input logic vld, input logic [23:0] dat,
                              input logic done);
    vec_t v;
    v.dv = dv; v.d = d; v.rd = rd; v.cnt = cnt; v.vld = vld; v.dat = dat; v.done = done;
    return v;
  endfunction

  int wins;
  int wrote;

  initial begin
    // Expected outputs as seen during each cycle, before its edge.
    tbl[0]  = mk(1, 8'd1, 0, 0, 0, 24'h0, 0);
    tbl[1]  = mk(1, 8'd2, 0, 1, 0, 24'h0, 0);
    tbl[2]  = mk(1, 8'd3, 0, 2, 0, 24'h0, 0);
    tbl[3]  = mk(1, 8'd4, 0, 3, 1, 24'h030201, 0);
    tbl[4]  = mk(1, 8'd5, 0, 4, 1, 24'h030201, 0);
    tbl[5]  = mk(1, 8'd6, 0, 5, 1, 24'h030201, 0);
    tbl[6]  = mk(1, 8'd7, 0, 6, 1, 24'h030201, 0);
    tbl[7]  = mk(1, 8'd8, 0, 7, 1, 24'h030201, 0);
    tbl[8]  = mk(0, 8'd0, 1, 8, 1, 24'h030201, 0);
    tbl[9]  = mk(0, 8'd0, 1, 7, 1, 24'h040302, 0);
    tbl[10] = mk(0, 8'd0, 1, 6, 1, 24'h050403, 0);
    tbl[11] = mk(0, 8'd0, 1, 5, 1, 24'h060504, 0);
    tbl[12] = mk(0, 8'd0, 1, 4, 1, 24'h070605, 0);
    tbl[13] = mk(0, 8'd0, 1, 3, 1, 24'h080706, 0);
    tbl[14] = mk(0, 8'd0, 0, 0, 0, 24'h0, 1);
    tbl[15] = mk(0, 8'd0, 0, 0, 0, 24'h0, 0);

    rst = 1'b1; data = '0; data_valid = 1'b0; rd_data = 1'b0;
    model_reset();
    #1;
    chk("init_count", 32'(count), 32'd0);
    chk("init_wr_ready", 32'(wr_ready), 32'd1);
    chk("init_valid", 32'(win_valid), 32'd0);
    chk("init_err", 32'(err), 32'd0);
    chk("init_done", 32'(line_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // One full line: windows {3,2,1}..{8,7,6}, then the line_done pulse.
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].dv, tbl[i].d, tbl[i].rd);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_valid", i), 32'(win_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_done", i), 32'(line_done), 32'(tbl[i].done));
      if (tbl[i].vld) chk($sformatf("tbl%0d_win", i), 32'(win), 32'(tbl[i].dat));
      commit();
    end

    // Overflow: a ninth write is refused.
    do_reset();
    for (int i = 0; i < LINE_W; i++) cyc(1, 8'(8'h10 + i), 0);
    apply(1, 8'hEE, 0);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    commit();
    apply(0, 8'h00, 0);
    chk("full_count", 32'(count), 32'd8);
`ifdef LB_ERR_FLAG_EN
    chk("ovf_err", 32'(err), 32'd1);
`else
    chk("ovf_err", 32'(err), 32'd0);
`endif
    commit();
    // Full buffer read and written together: the write is refused.
    cyc(1, 8'hDD, 1);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // Underflow: read with only two pixels present.
    do_reset();
    cyc(1, 8'hA1, 0);
    cyc(1, 8'hA2, 0);
    apply(0, 8'h00, 1);
    chk("udf_valid", 32'(win_valid), 32'd0);
    commit();
    apply(0, 8'h00, 0);
    chk("udf_count", 32'(count), 32'd2);
`ifdef LB_ERR_FLAG_EN
    chk("udf_err", 32'(err), 32'd2);
`else
    chk("udf_err", 32'(err), 32'd0);
`endif
    commit();
    for (int i = 0; i < 6; i++) cyc(1, 8'(8'hA3 + i), 0);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // Streaming over three lines.
    do_reset();
    wins = 0;
    wrote = 0;
    for (int c = 0; c < 40; c++) begin
      apply(wrote < 3 * LINE_W, 8'($urandom), q.size() >= TAPS);
      if (data_valid) wrote++;
      commit();
      if (last_ra) wins++;
    end
    chk("stream_windows", 32'(wins), 32'd18);
    apply(0, 8'h00, 0);
    chk("stream_count", 32'(count), 32'd0);
    chk("stream_err", 32'(err), 32'd0);
    commit();

    // Reset mid-line discards the partial line.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    do_reset();
    for (int i = 0; i < LINE_W; i++) cyc(1, 8'(8'h60 + i), 0);
    apply(0, 8'h00, 0);
    chk("post_rst_first_win", 32'(win), 32'h626160);
    commit();
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cyc(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 55));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
